// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path: reserved display codes,
// receiver FSM states, and the letter-to-symbol table also used by the
// transmitter. Symbol encoding: LSB is the first element, dot = 0, dash = 1.
package morse_pkg;

    localparam logic [4:0] CODE_EMPTY = 5'd31;
    localparam logic [4:0] CODE_SPACE = 5'd30;
    localparam int         NUM_LETTERS = 26;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MARK    = 2'd1,
        ST_SPACE   = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_e;

    // Returns {sym_len[2:0], sym_bits[3:0]} for letter index 0 (A) .. 25 (Z).
    // Unused high bits of sym_bits are always zero.
    function automatic logic [6:0] letter_sym(input logic [4:0] idx);
        logic [6:0] r;
        case (idx)
            5'd0:    r = {3'd2, 4'b0010}; // A .-
            5'd1:    r = {3'd4, 4'b0001}; // B -...
            5'd2:    r = {3'd4, 4'b0101}; // C -.-.
            5'd3:    r = {3'd3, 4'b0001}; // D -..
            5'd4:    r = {3'd1, 4'b0000}; // E .
            5'd5:    r = {3'd4, 4'b0100}; // F ..-.
            5'd6:    r = {3'd3, 4'b0011}; // G --.
            5'd7:    r = {3'd4, 4'b0000}; // H ....
            5'd8:    r = {3'd2, 4'b0000}; // I ..
            5'd9:    r = {3'd4, 4'b1110}; // J .---
            5'd10:   r = {3'd3, 4'b0101}; // K -.-
            5'd11:   r = {3'd4, 4'b0010}; // L .-..
            5'd12:   r = {3'd2, 4'b0011}; // M --
            5'd13:   r = {3'd2, 4'b0001}; // N -.
            5'd14:   r = {3'd3, 4'b0111}; // O ---
            5'd15:   r = {3'd4, 4'b0110}; // P .--.
            5'd16:   r = {3'd4, 4'b1011}; // Q --.-
            5'd17:   r = {3'd3, 4'b0010}; // R .-.
            5'd18:   r = {3'd3, 4'b0000}; // S ...
            5'd19:   r = {3'd1, 4'b0001}; // T -
            5'd20:   r = {3'd3, 4'b0100}; // U ..-
            5'd21:   r = {3'd4, 4'b1000}; // V ...-
            5'd22:   r = {3'd3, 4'b0110}; // W .--
            5'd23:   r = {3'd4, 4'b1001}; // X -..-
            5'd24:   r = {3'd4, 4'b1101}; // Y -.--
            5'd25:   r = {3'd4, 4'b0011}; // Z --..
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Run-length counter increment that holds at 15.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/morse_sym_decode.sv
// Combinational symbol-to-letter lookup; inverse of morse_pkg::letter_sym.
// Patterns not in the table (including sym_len 0) report valid = 0.
module morse_sym_decode
    import morse_pkg::*;
(
    input  logic [3:0] sym_bits,
    input  logic [2:0] sym_len,
    output logic       valid,
    output logic [4:0] code
);

    logic [6:0] entry;

    // Search the letter table for an exact length and pattern match.
    always_comb begin
        valid = 1'b0;
        code  = 5'd0;
        entry = 7'd0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            entry = letter_sym(5'(i));
            if (!valid && entry[6:4] == sym_len && entry[3:0] == sym_bits) begin
                valid = 1'b1;
                code  = 5'(i);
            end
        end
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: samples iLine on every change of iHalfSec, measures mark and
// space run lengths, assembles dot/dash symbols and decodes them into letter
// codes that shift into a 7-character display buffer (newest in [4:0]).
// Optional word-space insertion is built when MORSE_RX_WORDGAP_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | between characters, waiting for an ON tick
// ST_MARK    | line ON, counting mark length
// ST_SPACE   | line OFF inside a character, counting toward the character gap
// ST_DISCARD | malformed character, waiting for a character gap to resync
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX  = 2,
    parameter int DASH_MAX = 4,
    parameter int CHAR_GAP = 3
`ifdef MORSE_RX_WORDGAP_EN
    ,
    parameter int WORD_GAP = 7
`endif
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEnable,
    input  logic        iLine,
    input  logic [3:0]  iHalfSec,
    input  logic        iClear,
    output logic [34:0] oDisplayData,
    output logic [4:0]  oChar,
    output logic        oCharValid,
    output logic        oError,
    output logic        oBusy
);

    localparam logic [34:0] DISP_EMPTY = {7{CODE_EMPTY}};

    rx_state_e   state_q, state_d;
    logic [3:0]  prev_half_sec_q, prev_half_sec_d;
    logic [3:0]  mark_cnt_q, mark_cnt_d;
    logic [3:0]  space_cnt_q, space_cnt_d;
    logic [3:0]  sym_bits_q, sym_bits_d;
    logic [2:0]  sym_len_q, sym_len_d;
    logic [34:0] disp_q, disp_d;
    logic [4:0]  char_q, char_d;
    logic        char_valid_q, char_valid_d;
    logic        error_q, error_d;
`ifdef MORSE_RX_WORDGAP_EN
    logic [3:0]  idle_cnt_q, idle_cnt_d;
    logic        word_armed_q, word_armed_d;
`endif

    logic        tick;
    logic        commit;
    logic [4:0]  commit_code;
    logic        dec_valid;
    logic [4:0]  dec_code;

    morse_sym_decode u_sym_decode (
        .sym_bits (sym_bits_q),
        .sym_len  (sym_len_q),
        .valid    (dec_valid),
        .code     (dec_code)
    );

    // Next-state, symbol assembly, commit and display-buffer update.
    always_comb begin
        state_d         = state_q;
        prev_half_sec_d = iHalfSec;
        mark_cnt_d      = mark_cnt_q;
        space_cnt_d     = space_cnt_q;
        sym_bits_d      = sym_bits_q;
        sym_len_d       = sym_len_q;
        disp_d          = disp_q;
        char_d          = char_q;
        char_valid_d    = 1'b0;
        error_d         = 1'b0;
        commit          = 1'b0;
        commit_code     = 5'd0;
`ifdef MORSE_RX_WORDGAP_EN
        idle_cnt_d      = idle_cnt_q;
        word_armed_d    = word_armed_q;
`endif
        tick = (iHalfSec != prev_half_sec_q);

        if (!iEnable) begin
            state_d     = ST_IDLE;
            mark_cnt_d  = 4'd0;
            space_cnt_d = 4'd0;
            sym_bits_d  = 4'd0;
            sym_len_d   = 3'd0;
`ifdef MORSE_RX_WORDGAP_EN
            idle_cnt_d   = 4'd0;
            word_armed_d = 1'b0;
`endif
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (iLine) begin
                        state_d    = ST_MARK;
                        mark_cnt_d = 4'd1;
`ifdef MORSE_RX_WORDGAP_EN
                        idle_cnt_d   = 4'd0;
                        word_armed_d = 1'b0;
`endif
                    end
`ifdef MORSE_RX_WORDGAP_EN
                    else if (word_armed_q) begin
                        idle_cnt_d = sat_inc(idle_cnt_q);
                        if (idle_cnt_d == 4'(WORD_GAP)) begin
                            commit       = 1'b1;
                            commit_code  = CODE_SPACE;
                            word_armed_d = 1'b0;
                        end
                    end
`endif
                end
                ST_MARK: begin
                    if (iLine) begin
                        mark_cnt_d = sat_inc(mark_cnt_q);
                        if (mark_cnt_d > 4'(DASH_MAX)) begin
                            error_d     = 1'b1;
                            state_d     = ST_DISCARD;
                            mark_cnt_d  = 4'd0;
                            space_cnt_d = 4'd0;
                        end
                    end else if (sym_len_q == 3'd4) begin
                        // This OFF tick already counts toward the resync gap.
                        error_d     = 1'b1;
                        state_d     = ST_DISCARD;
                        mark_cnt_d  = 4'd0;
                        space_cnt_d = 4'd1;
                    end else begin
                        sym_bits_d[sym_len_q[1:0]] = (mark_cnt_q > 4'(DOT_MAX));
                        sym_len_d   = sym_len_q + 3'd1;
                        state_d     = ST_SPACE;
                        mark_cnt_d  = 4'd0;
                        space_cnt_d = 4'd1;
                    end
                end
                ST_SPACE: begin
                    if (iLine) begin
                        state_d     = ST_MARK;
                        mark_cnt_d  = 4'd1;
                        space_cnt_d = 4'd0;
                    end else begin
                        space_cnt_d = sat_inc(space_cnt_q);
                        if (space_cnt_d == 4'(CHAR_GAP)) begin
                            if (dec_valid) begin
                                commit      = 1'b1;
                                commit_code = dec_code;
`ifdef MORSE_RX_WORDGAP_EN
                                word_armed_d = 1'b1;
                                idle_cnt_d   = 4'd0;
`endif
                            end else begin
                                error_d = 1'b1;
                            end
                            state_d     = ST_IDLE;
                            space_cnt_d = 4'd0;
                            sym_bits_d  = 4'd0;
                            sym_len_d   = 3'd0;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (iLine) begin
                        space_cnt_d = 4'd0;
                    end else begin
                        space_cnt_d = sat_inc(space_cnt_q);
                        if (space_cnt_d == 4'(CHAR_GAP)) begin
                            state_d     = ST_IDLE;
                            space_cnt_d = 4'd0;
                            sym_bits_d  = 4'd0;
                            sym_len_d   = 3'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A clear request overrides a same-cycle commit entirely.
        if (iClear) begin
            disp_d = DISP_EMPTY;
        end else if (commit) begin
            disp_d       = {disp_q[29:0], commit_code};
            char_d       = commit_code;
            char_valid_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q         <= ST_IDLE;
            prev_half_sec_q <= 4'd0;
            mark_cnt_q      <= 4'd0;
            space_cnt_q     <= 4'd0;
            sym_bits_q      <= 4'd0;
            sym_len_q       <= 3'd0;
            disp_q          <= DISP_EMPTY;
            char_q          <= 5'd0;
            char_valid_q    <= 1'b0;
            error_q         <= 1'b0;
`ifdef MORSE_RX_WORDGAP_EN
            idle_cnt_q      <= 4'd0;
            word_armed_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            prev_half_sec_q <= prev_half_sec_d;
            mark_cnt_q      <= mark_cnt_d;
            space_cnt_q     <= space_cnt_d;
            sym_bits_q      <= sym_bits_d;
            sym_len_q       <= sym_len_d;
            disp_q          <= disp_d;
            char_q          <= char_d;
            char_valid_q    <= char_valid_d;
            error_q         <= error_d;
`ifdef MORSE_RX_WORDGAP_EN
            idle_cnt_q      <= idle_cnt_d;
            word_armed_q    <= word_armed_d;
`endif
        end
    end

    assign oDisplayData = disp_q;
    assign oChar        = char_q;
    assign oCharValid   = char_valid_q;
    assign oError       = error_q;
    assign oBusy        = (state_q != ST_IDLE);

endmodule
